mod7_seq_monitor: RTL and testbench
===================================

# mod7_seq_monitor

Downstream consumer of the JK-based modulo-7 counter. Samples the counter's three state bits every clock and checks each step against the legal modulo-7 sequence. Counts completed cycles, latches and counts sequence faults, and optionally drives a seven-segment digit of the current count. Sits between the counter and the board display/status LEDs.

## Interface
- `CW`, default 8: width of the completed-cycle counter.
- `RESYNC`, default 2: consecutive legal steps required to leave FAULT (range 1–7).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `set_in` in 1: copy of the counter's `set` input. When high, the next counter value is 7.
- `q2`, `q1`, `q0` in 1 each: counter state bits, MSB first.
- `digit` out 3: registered copy of the last sampled count.
- `wrap` out 1: one-cycle pulse on each legal 6→0 step.
- `cycles` out CW: number of completed cycles, wraps modulo 2^CW.
- `err` out 1: sticky fault flag, cleared only by `rst`.
- `err_cnt` out 8: number of faults, saturates at 255.
- `st` out 2: FSM state (00 IDLE, 01 TRACK, 10 FAULT).
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-high.

## Operation
- Sample register: at each edge, `cur` <= {q2,q1,q0} and `prev` <= `cur`; `set_d` <= `set_in`.
- Expected successor `exp(prev)`:
  - If `set_d`=1, exp = 7.
  - Else if prev=6, exp = 0.
  - Else if prev=7, exp = 0.
  - Else exp = prev+1.
- Legal step: `cur` == `exp(prev)`.
- FSM states:
  - IDLE: entered on reset. No comparison is made because `prev` is not yet valid. After one edge with a sample captured, go to TRACK.
  - TRACK:
    - Legal step: stay in TRACK.
    - Illegal step: go to FAULT, set `err`=1, increment `err_cnt`.
  - FAULT:
    - Holds a resync counter. It increments on each legal step and clears on each illegal step.
    - Each illegal step in FAULT also increments `err_cnt`.
    - When the resync counter reaches RESYNC, go to TRACK.
- `wrap` fires on a legal step with prev=6, cur=0, in TRACK or FAULT. When `wrap` fires, `cycles` increments, wrapping from 2^CW−1 to 0.
- Value 7 is the preset state. 7→0 is legal and does not assert `wrap`.
- `set_in` has priority. The step following `set_in`=1 is never reported as an error, even if `cur`≠7. In that case `prev` is reloaded and tracking continues from `cur`.
- `err_cnt` holds at 255 and never rolls over.

## Timing
- Reset values: `digit`=0, `wrap`=0, `cycles`=0, `err`=0, `err_cnt`=0, `st`=IDLE, `seg`=7'h00 (blank).
- Reset takes effect at the next rising edge with `rst`=1. It overrides all other activity, including in mid-FAULT and mid-wrap.
- Latency:
  - A count presented before edge k is in `cur` and on `digit` after edge k.
  - Its check result (`wrap`, `err`, `err_cnt`, `st`) is visible after edge k+1.
  - `seg` is visible after edge k+1.
- The first comparison after reset uses the samples from edges 1 and 2. Its result is visible after edge 3.
- `wrap` is high for exactly one cycle per legal 6→0 step. There is no throughput restriction; the counter may advance every clock.
- `set_in` sampled at edge k suppresses checking of the step whose result appears after edge k+2.

## Configuration
- `MOD7_MON_SEG7_EN` defined:
  - `seg` is registered from `cur` with the standard hex decode: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D.
  - 7 shows a dash (40).
  - While `st`=FAULT, `seg` shows 79 ('E').
- `MOD7_MON_SEG7_EN` not defined: `seg` is constant 7'h00 and no decode logic is built. All other outputs are unchanged.

## Test plan
- Reset, then feed 0,1,…,6,0 repeatedly for 3 cycles -> `err`=0, `st`=TRACK; `wrap` pulses 3 times, each one cycle; `cycles`=3.
- Pulse `set_in`, then feed 7,0,1 -> no error; no `wrap` on 7→0; `digit` follows 7,0,1 one edge later.
- In TRACK, inject 3→5, then feed 6,0 -> `err`=1, `err_cnt`=1, `st`=FAULT. With RESYNC=2, `st` returns to TRACK after the 6→0 step. The 6→0 step also pulses `wrap`.
- Feed alternating 0,3 for 300 cycles -> `err_cnt` saturates at 255; `st` stays FAULT; `err` stays 1.
- Start at `cycles`=255 with CW=8, then complete one more 6→0 -> `cycles`=0; `wrap` pulses once.
- Assert `rst` mid-FAULT, then apply a legal sequence. With `MOD7_MON_SEG7_EN` defined: after the `rst` edge, all outputs are at reset values and `seg`=00; once the sequence is running, `seg` shows 3F for count 0 and 7D for count 6.

Source files
------------

// File: rtl/mod7_seq_monitor.sv
// mod7_seq_monitor: samples a JK modulo-7 counter every clock and checks each
// step against the legal 0..6 sequence (7 is the preset state). Counts
// completed cycles, latches and counts faults. The seven-segment output is
// built only when MOD7_MON_SEG7_EN is defined; otherwise seg is tied to 0.
module mod7_seq_monitor #(
    parameter int unsigned CW     = 8,
    parameter int unsigned RESYNC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_in,
    input  logic          q2,
    input  logic          q1,
    input  logic          q0,
    output logic [2:0]    digit,
    output logic          wrap,
    output logic [CW-1:0] cycles,
    output logic          err,
    output logic [7:0]    err_cnt,
    output logic [1:0]    st,
    output logic [6:0]    seg
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } state_t;

    localparam logic [2:0] RESYNC_N = 3'(RESYNC);

    state_t     state;
    logic [2:0] cur;
    logic [2:0] prev;
    logic       set_d;
    logic       set_d2;
    logic       primed;
    logic [2:0] rc;

    logic [2:0] exp_val;
    logic       legal;
    logic       wrap_step;

    // set_d2 carries the set sampled together with prev, so it governs the
    // prev -> cur step currently being judged.
    always_comb begin
        exp_val = prev + 3'd1;
        if (set_d2) begin
            exp_val = 3'd7;
        end else if (prev == 3'd6 || prev == 3'd7) begin
            exp_val = 3'd0;
        end
        // a step right after a preset is never an error, whatever cur is
        legal     = set_d2 || (cur == exp_val);
        wrap_step = legal && !set_d2 && (prev == 3'd6) && (cur == 3'd0);
    end

    // Sampling pipeline, sequence-check FSM and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= 3'd0;
            prev    <= 3'd0;
            set_d   <= 1'b0;
            set_d2  <= 1'b0;
            primed  <= 1'b0;
            state   <= IDLE;
            rc      <= 3'd0;
            wrap    <= 1'b0;
            cycles  <= '0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            cur    <= {q2, q1, q0};
            prev   <= cur;
            set_d  <= set_in;
            set_d2 <= set_d;
            primed <= 1'b1;
            wrap   <= 1'b0;
            case (state)
                IDLE: begin
                    // prev becomes valid one edge after the first sample
                    if (primed) begin
                        state <= TRACK;
                    end
                end
                TRACK: begin
                    if (!legal) begin
                        state <= FAULT;
                        err   <= 1'b1;
                        rc    <= 3'd0;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end else if (wrap_step) begin
                        wrap   <= 1'b1;
                        cycles <= cycles + CW'(1);
                    end
                end
                FAULT: begin
                    if (legal) begin
                        if (wrap_step) begin
                            wrap   <= 1'b1;
                            cycles <= cycles + CW'(1);
                        end
                        if (rc + 3'd1 == RESYNC_N) begin
                            state <= TRACK;
                            rc    <= 3'd0;
                        end else begin
                            rc <= rc + 3'd1;
                        end
                    end else begin
                        rc <= 3'd0;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign digit = cur;
    assign st    = state;

`ifdef MOD7_MON_SEG7_EN
    logic to_fault;

    // Next state is FAULT: the display shows 'E' in step with st.
    always_comb begin
        to_fault = 1'b0;
        case (state)
            TRACK:   to_fault = !legal;
            FAULT:   to_fault = !(legal && (rc + 3'd1 == RESYNC_N));
            default: to_fault = 1'b0;
        endcase
    end

    function automatic logic [6:0] seg_decode(input logic [2:0] v);
        logic [6:0] s;
        case (v)
            3'd0:    s = 7'h3F;
            3'd1:    s = 7'h06;
            3'd2:    s = 7'h5B;
            3'd3:    s = 7'h4F;
            3'd4:    s = 7'h66;
            3'd5:    s = 7'h6D;
            3'd6:    s = 7'h7D;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Registered seven-segment digit of the current count.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 7'h00;
        end else if (to_fault) begin
            seg <= 7'h79;
        end else begin
            seg <= seg_decode(cur);
        end
    end
`else
    assign seg = 7'h00;
`endif

endmodule

// File: tb/tb_mod7_seq_monitor.sv
// Scoreboard bench for mod7_seq_monitor: the driver pushes the expected
// outputs for every edge, a monitor pops and compares on the falling edge.
module tb_mod7_seq_monitor;

    localparam int unsigned CW     = 8;
    localparam int unsigned RESYNC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          set_in;
    logic          q2, q1, q0;
    logic [2:0]    digit;
    logic          wrap;
    logic [CW-1:0] cycles;
    logic          err;
    logic [7:0]    err_cnt;
    logic [1:0]    st;
    logic [6:0]    seg;

    always #5 clk = ~clk;

    mod7_seq_monitor #(.CW(CW), .RESYNC(RESYNC)) dut (
        .clk(clk), .rst(rst), .set_in(set_in),
        .q2(q2), .q1(q1), .q0(q0),
        .digit(digit), .wrap(wrap), .cycles(cycles), .err(err),
        .err_cnt(err_cnt), .st(st), .seg(seg)
    );

    typedef struct packed {
        logic [2:0]    digit;
        logic          wrap;
        logic [CW-1:0] cycles;
        logic          err;
        logic [7:0]    err_cnt;
        logic [1:0]    st;
        logic [6:0]    seg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: full sample history since reset (index 0 = reset value).
    int samp[$];
    int sset[$];
    int mstate = 0;   // 0 idle, 1 track, 2 fault
    int mrc    = 0;
    int merr   = 0;
    int mecnt  = 0;
    int mcyc   = 0;
    int mwrap  = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    function automatic int seg_of(input int v);
        case (v)
            0: return 'h3F;
            1: return 'h06;
            2: return 'h5B;
            3: return 'h4F;
            4: return 'h66;
            5: return 'h6D;
            6: return 'h7D;
            default: return 'h40;
        endcase
    endfunction

    // Apply one edge of stimulus, advance the model, queue the expectation.
    task automatic step(input logic r, input logic s, input int q);
        int   e, a, b, ex, succ, ok;
        exp_t x;
        rst = r;
        set_in = s;
        {q2, q1, q0} = 3'(q);
        @(posedge clk);
        #1;
        mwrap = 0;
        if (r) begin
            samp.delete(); sset.delete();
            samp.push_back(0); sset.push_back(0);
            mstate = 0; mrc = 0; merr = 0; mecnt = 0; mcyc = 0;
        end else begin
            samp.push_back(q); sset.push_back(int'(s));
            e = samp.size() - 1;
            if (e == 2) mstate = 1;
            else if (e >= 3) begin
                a = samp[e-2]; b = samp[e-1]; ex = sset[e-2];
                succ = (a >= 6) ? 0 : a + 1;
                ok = (ex != 0) || (b == succ);
                if (ok == 0) begin
                    if (mstate == 1) begin mstate = 2; merr = 1; end
                    mrc = 0;
                    if (mecnt < 255) mecnt++;
                end else begin
                    if (ex == 0 && a == 6 && b == 0) begin
                        mwrap = 1;
                        mcyc = (mcyc + 1) % (1 << CW);
                    end
                    if (mstate == 2) begin
                        mrc++;
                        if (mrc == RESYNC) begin mstate = 1; mrc = 0; end
                    end
                end
            end
        end
        e = samp.size() - 1;
        x.digit   = 3'(samp[e]);
        x.wrap    = 1'(mwrap);
        x.cycles  = CW'(mcyc);
        x.err     = 1'(merr);
        x.err_cnt = 8'(mecnt);
        x.st      = 2'(mstate);
`ifdef MOD7_MON_SEG7_EN
        if (r) x.seg = 7'h00;
        else if (mstate == 2) x.seg = 7'h79;
        else x.seg = 7'(seg_of(samp[e-1]));
`else
        x.seg = 7'h00;
`endif
        exp_q.push_back(x);
    endtask

    // Monitor: one expectation per edge, compared away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t x;
            x = exp_q.pop_front();
            check("digit",   int'(digit),   int'(x.digit));
            check("wrap",    int'(wrap),    int'(x.wrap));
            check("cycles",  int'(cycles),  int'(x.cycles));
            check("err",     int'(err),     int'(x.err));
            check("err_cnt", int'(err_cnt), int'(x.err_cnt));
            check("st",      int'(st),      int'(x.st));
            check("seg",     int'(seg),     int'(x.seg));
        end
    end

    initial begin
        int cnt;
        int q;
        logic r, s;

        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        check("reset_st", int'(st), 0);
        check("reset_seg", int'(seg), 0);

        // three full legal cycles
        for (int lap = 0; lap < 3; lap++)
            for (int v = 0; v < 7; v++) step(1'b0, 1'b0, v);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1);
        check("three_cycles", int'(cycles), 3);
        check("three_cycles_err", int'(err), 0);
        check("three_cycles_st", int'(st), 1);

        // preset, then 7,0,1
        step(1'b0, 1'b1, 2);
        step(1'b0, 1'b0, 7);
        check("preset_digit", int'(digit), 7);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1);
        check("preset_no_wrap", int'(wrap), 0);
        check("preset_no_err", int'(err), 0);

        // inject 3->5, then recover on 5->6->0
        step(1'b0, 1'b0, 2);
        step(1'b0, 1'b0, 3);
        step(1'b0, 1'b0, 5);
        step(1'b0, 1'b0, 6);
        check("inject_err", int'(err), 1);
        check("inject_err_cnt", int'(err_cnt), 1);
        check("inject_st", int'(st), 2);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1);
        check("resync_st", int'(st), 1);
        check("resync_wrap", int'(wrap), 1);

        // saturate err_cnt
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, (i % 2 == 0) ? 0 : 3);
        check("sat_err_cnt", int'(err_cnt), 255);
        check("sat_st", int'(st), 2);
        check("sat_err", int'(err), 1);

        // cycles rollover
        step(1'b1, 1'b0, 0);
        for (int lap = 0; lap < 256; lap++)
            for (int v = 0; v < 7; v++) step(1'b0, 1'b0, v);
        step(1'b0, 1'b0, 0);
        check("cycles_max", int'(cycles), 255);
        step(1'b0, 1'b0, 1);
        check("cycles_roll", int'(cycles), 0);
        check("cycles_roll_wrap", int'(wrap), 1);

        // reset in mid-FAULT, then a legal run
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 4);
        step(1'b0, 1'b0, 2);
        step(1'b1, 1'b0, 5);
        check("midfault_rst_err", int'(err), 0);
        check("midfault_rst_cnt", int'(err_cnt), 0);
        check("midfault_rst_seg", int'(seg), 0);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1);
`ifdef MOD7_MON_SEG7_EN
        check("seg_zero", int'(seg), 'h3F);
`endif
        for (int v = 2; v < 7; v++) step(1'b0, 1'b0, v);
        step(1'b0, 1'b0, 0);
`ifdef MOD7_MON_SEG7_EN
        check("seg_six", int'(seg), 'h7D);
`endif

        // randomized counter behaviour with faults, presets and resets
        cnt = 1;
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 9) == 0);
            q = cnt;
            if ($urandom_range(0, 19) == 0) q = int'($urandom_range(0, 7));
            step(r, s, q);
            if (r) cnt = 0;
            else if (s) cnt = 7;
            else cnt = (q >= 6) ? 0 : q + 1;
        end

        repeat (3) @(negedge clk);
        check("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
